dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 40 ++++
 rtl/dmem_arbiter_rr.sv | 35 +++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM encoding, access-type codes and the legality check.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RESP
  } state_e;

  localparam logic [2:0] CTRL_B     = 3'b000;
  localparam logic [2:0] CTRL_H     = 3'b001;
  localparam logic [2:0] CTRL_W     = 3'b010;
  localparam logic [2:0] CTRL_BU    = 3'b100;
  localparam logic [2:0] CTRL_HU    = 3'b101;
  localparam logic [2:0] DMCTRL_NOP = 3'b011;

  // Type, alignment and range check for one request.
  function automatic logic req_legal(
    input logic        wr,
    input logic [2:0]  ctrl,
    input logic [31:0] addr,
    input logic [31:0] lim
  );
    logic ok;
    ok = 1'b0;
    case (ctrl)
      CTRL_B:  ok = 1'b1;
      CTRL_H:  ok = ~addr[0];
      CTRL_W:  ok = (addr[1:0] == 2'b00);
      CTRL_BU: ok = ~wr;
      CTRL_HU: ok = ~wr & ~addr[0];
      default: ok = 1'b0;
    endcase
    if (addr >= lim) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin arbiter with a last-grant register.
// Bit 0 is the CPU port, bit 1 the debug/DMA port.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // Pick the single requester, or the one not granted last on a tie.
  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      (req_i == 2'b11): gnt_o = last_q ? 2'b01 : 2'b10;
      default:          gnt_o = 2'b00;
    endcase
  end

  assign last_d = (en_i && |req_i) ? gnt_o[1] : last_q;

  // Last-grant register; reset to D so C wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with a four-state access FSM.
// Memory is driven only in SETUP/STROBE; DMWr comes from a flop.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        C_Req,
  input  logic        C_Wr,
  input  logic [31:0] C_Addr,
  input  logic [31:0] C_WData,
  input  logic [2:0]  C_Ctrl,
  output logic        C_Gnt,
  output logic        C_Done,
  output logic [31:0] C_RData,
  output logic        C_Err,
  input  logic        D_Req,
  input  logic        D_Wr,
  input  logic [31:0] D_Addr,
  input  logic [31:0] D_WData,
  input  logic [2:0]  D_Ctrl,
  output logic        D_Gnt,
  output logic        D_Done,
  output logic [31:0] D_RData,
  output logic        D_Err,
  output logic [31:0] Address,
  output logic [31:0] DataWr,
  output logic        DMWr,
  output logic [2:0]  DMCtrl,
  input  logic [31:0] DataRd
);

  localparam logic [31:0] ADDR_LIM = 32'(MEM_WORDS * 4);

  state_e      state_q, state_d;
  logic        port_q, port_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gnt_q, gnt_d;
  logic        dmwr_q;

  logic [1:0]  gnt;
  logic        arb_en;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_ctrl;
  logic        sel_ok;
  logic        mem_act;
  logic        resp;
  logic        rd_ok;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({D_Req, C_Req}),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign sel_wr    = gnt[1] ? D_Wr    : C_Wr;
  assign sel_addr  = gnt[1] ? D_Addr  : C_Addr;
  assign sel_wdata = gnt[1] ? D_WData : C_WData;
  assign sel_ctrl  = gnt[1] ? D_Ctrl  : C_Ctrl;
  assign sel_ok    = req_legal(sel_wr, sel_ctrl,
                               sel_addr, ADDR_LIM);

  // Next-state and latch logic for the access sequence.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    gnt_d   = 1'b0;
    arb_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          arb_en  = 1'b1;
          port_d  = gnt[1];
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          ctrl_d  = sel_ctrl;
          err_d   = ~sel_ok;
          rdata_d = '0;
          gnt_d   = 1'b1;
          state_d = sel_ok ? S_SETUP : S_RESP;
        end
      end
      S_SETUP: begin
        if (wr_q) begin
          state_d = S_STROBE;
        end else begin
          rdata_d = DataRd;
          state_d = S_RESP;
        end
      end
      S_STROBE: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, latched request and glitch-free write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= DMCTRL_NOP;
      err_q   <= 1'b0;
      rdata_q <= '0;
      gnt_q   <= 1'b0;
      dmwr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      dmwr_q  <= (state_d == S_STROBE);
    end
  end

  assign mem_act = (state_q == S_SETUP) ||
                   (state_q == S_STROBE);
  assign resp    = (state_q == S_RESP);
  assign rd_ok   = resp & ~wr_q & ~err_q;

  assign Address = mem_act ? addr_q  : '0;
  assign DataWr  = mem_act ? wdata_q : '0;
  assign DMCtrl  = mem_act ? ctrl_q  : DMCTRL_NOP;
  assign DMWr    = dmwr_q;

  assign C_Gnt   = gnt_q & ~port_q;
  assign D_Gnt   = gnt_q &  port_q;
  assign C_Done  = resp & ~port_q;
  assign D_Done  = resp &  port_q;
  assign C_Err   = C_Done & err_q;
  assign D_Err   = D_Done & err_q;
  assign C_RData = (rd_ok & ~port_q) ? rdata_q : '0;
  assign D_RData = (rd_ok &  port_q) ? rdata_q : '0;

endmodule
